// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_pkg                                                                  |
// | Widths and FSM encoding shared by the FFT scheduler, twiddle ROM and     |
// | butterfly datapath.                                                      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package fft_pkg;

    localparam int LOG2N_DEF = 3;
    localparam int N_DEF     = 1 << LOG2N_DEF;
    localparam int ADDR_W    = LOG2N_DEF;
    localparam int TW_W      = LOG2N_DEF - 1;
    localparam int STAGE_W   = $clog2(LOG2N_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_pair_addr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_pair_addr                                                            |
// | Combinational (stage, pair) -> operand addresses and twiddle index for   |
// | an in-place radix-2 DIT butterfly.                                       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module fft_pair_addr
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic [$clog2(LOG2N)-1:0] s,
    input  logic [LOG2N-2:0]         j,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx
);

    localparam int c_stage_w = $clog2(LOG2N);

    logic [LOG2N-1:0]     w_j;
    logic [LOG2N-1:0]     w_span;
    logic [LOG2N-1:0]     w_mask;
    logic [LOG2N-1:0]     w_pos;
    logic [c_stage_w-1:0] w_tw_sh;

    // Group bits of j shift up one place to open the gap for the b operand.
    always_comb begin
        w_j     = {1'b0, j};
        w_span  = LOG2N'(1) << s;
        w_mask  = w_span - LOG2N'(1);
        w_pos   = w_j & w_mask;
        addr_a  = ((w_j & ~w_mask) << 1) | w_pos;
        addr_b  = addr_a | w_span;
        w_tw_sh = c_stage_w'(LOG2N - 1) - s;
        tw_idx  = w_pos[LOG2N-2:0] << w_tw_sh;
    end

endmodule
`default_nettype wire

// File: rtl/fft_bfly_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_bfly_sched                                                           |
// | Radix-2 DIT butterfly issue scheduler with outstanding-writeback         |
// | throttle and stage barrier. FFT_SCHED_INV_EN adds inv / tw_conj.         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module fft_bfly_sched
    import fft_pkg::*;
#(
    parameter int LOG2N   = LOG2N_DEF,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_idx,
    output logic [$clog2(LOG2N)-1:0] stage,
    input  logic                     wb_ack,
`ifdef FFT_SCHED_INV_EN
    input  logic                     inv,
    output logic                     tw_conj,
`endif
    output logic                     err
);

    localparam int c_stage_w = $clog2(LOG2N);
    localparam int c_j_w     = LOG2N - 1;
    localparam int c_out_w   = $clog2(MAX_OUT + 1);
    localparam logic [c_j_w-1:0]     c_j_last  = '1;
    localparam logic [c_stage_w-1:0] c_s_last  = c_stage_w'(LOG2N - 1);
    localparam logic [c_out_w-1:0]   c_max_out = c_out_w'(MAX_OUT);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [c_stage_w-1:0] r_s;
    logic [c_stage_w-1:0] w_s_nxt;
    logic [c_j_w-1:0]     r_j;
    logic [c_j_w-1:0]     w_j_nxt;
    logic [c_out_w-1:0]   r_out;
    logic [c_out_w-1:0]   w_out_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;
    logic                 r_err;
    logic [LOG2N-1:0]     r_addr_a;
    logic [LOG2N-1:0]     r_addr_b;
    logic [c_j_w-1:0]     r_tw;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;
    logic [LOG2N-1:0]     w_pair_a;
    logic [LOG2N-1:0]     w_pair_b;
    logic [c_j_w-1:0]     w_pair_tw;
    logic [LOG2N-1:0]     w_addr_a_nxt;
    logic [LOG2N-1:0]     w_addr_b_nxt;
    logic [c_j_w-1:0]     w_tw_nxt;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_ack_ok;
    logic                 w_ack_bad;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_xfer    = r_valid && iss_ready;
    assign w_ack_bad = wb_ack && (r_out == '0);
    assign w_ack_ok  = wb_ack && !w_ack_bad;
    // Cannot wrap: issue stops at MAX_OUT and a stray ack is absorbed at zero.
    assign w_out_nxt = r_out + c_out_w'(w_xfer) - c_out_w'(w_ack_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_xfer && (r_j == c_j_last)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_out_nxt == '0) w_state_nxt = (r_s == c_s_last) ? ST_FIN : ST_RUN;
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    fft_pair_addr #(
        .LOG2N (LOG2N)
    ) u_pair_addr (
        .s      (w_s_nxt),
        .j      (w_j_nxt),
        .addr_a (w_pair_a),
        .addr_b (w_pair_b),
        .tw_idx (w_pair_tw)
    );

    always_comb begin
        w_s_nxt = r_s;
        w_j_nxt = r_j;
        if (w_accept) begin
            w_s_nxt = '0;
            w_j_nxt = '0;
        end else if ((r_state == ST_RUN) && w_xfer && (r_j != c_j_last)) begin
            w_j_nxt = r_j + c_j_w'(1);
        end else if ((r_state == ST_DRAIN) && (w_state_nxt == ST_RUN)) begin
            w_s_nxt = r_s + c_stage_w'(1);
            w_j_nxt = '0;
        end
        w_busy_nxt  = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
        w_done_nxt  = (w_state_nxt == ST_FIN);
        w_valid_nxt = (w_state_nxt == ST_RUN) && (w_out_nxt < c_max_out);
        w_err_nxt   = (r_err && !w_accept) || w_ack_bad;
        w_addr_a_nxt = '0;
        w_addr_b_nxt = '0;
        w_tw_nxt     = '0;
        if (w_state_nxt == ST_RUN) begin
            w_addr_a_nxt = w_pair_a;
            w_addr_b_nxt = w_pair_b;
            w_tw_nxt     = w_pair_tw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s      <= '0;
            r_j      <= '0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_tw     <= '0;
        end else begin
            r_s      <= w_s_nxt;
            r_j      <= w_j_nxt;
            r_out    <= w_out_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_addr_a <= w_addr_a_nxt;
            r_addr_b <= w_addr_b_nxt;
            r_tw     <= w_tw_nxt;
        end
    end

`ifdef FFT_SCHED_INV_EN
    logic r_tw_conj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tw_conj <= 1'b0;
        end else if (w_accept) begin
            r_tw_conj <= inv;
        end
    end

    assign tw_conj = r_tw_conj;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign iss_valid = r_valid;
    assign addr_a    = r_addr_a;
    assign addr_b    = r_addr_b;
    assign tw_idx    = r_tw;
    assign stage     = r_s;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fft_bfly_sched                                                        |
// | Directed self-checking bench for fft_bfly_sched, LOG2N=3, MAX_OUT=2.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_fft_bfly_sched;

    localparam int LOG2N   = 3;
    localparam int MAX_OUT = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic       iss_ready = 1'b1;
    logic       wb_ack    = 1'b0;
    logic       busy;
    logic       done;
    logic       iss_valid;
    logic       err;
    logic [2:0] addr_a;
    logic [2:0] addr_b;
    logic [1:0] tw_idx;
    logic [1:0] stage;
`ifdef FFT_SCHED_INV_EN
    logic       inv = 1'b0;
    logic       tw_conj;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int oc;
    int s1_seen;

    int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    always #5 clk = ~clk;

    fft_bfly_sched #(
        .LOG2N   (LOG2N),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .tw_idx    (tw_idx),
        .stage     (stage),
        .wb_ack    (wb_ack),
`ifdef FFT_SCHED_INV_EN
        .inv       (inv),
        .tw_conj   (tw_conj),
`endif
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_done"},  done,      0);
        chk({tag, "_valid"}, iss_valid, 0);
        chk({tag, "_err"},   err,       0);
        chk({tag, "_a"},     addr_a,    0);
        chk({tag, "_b"},     addr_b,    0);
        chk({tag, "_tw"},    tw_idx,    0);
        chk({tag, "_stage"}, stage,     0);
    endtask

    // One full transform; acks land one cycle after each issue unless delayed.
    task automatic run_xform(input int hold_idx, input int hold_len, input int delay_idx,
                             input int delay_len, input int mid_start_cyc,
                             input int exp_done_cyc, input bit inv_v);
        int n;
        int done_cyc;
        int hold_cnt;
        int s0_ack_cyc;
        int dones;
        int due;
        bit fin;
        int ack_q[$];
        n = 0; done_cyc = -1; hold_cnt = 0; s0_ack_cyc = -1; dones = 0; fin = 1'b0;
        @(negedge clk);
        start = 1'b1; iss_ready = 1'b1; wb_ack = 1'b0;
`ifdef FFT_SCHED_INV_EN
        inv = inv_v;
`endif
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                chk("lat_valid", iss_valid, 1);
                chk("lat_busy", busy, 1);
`ifdef FFT_SCHED_INV_EN
                chk("tw_conj_run", tw_conj, inv_v);
`endif
            end
            wb_ack = 1'b0;
            for (int i = 0; i < ack_q.size(); i++) begin
                if (ack_q[i] == cyc) begin
                    wb_ack = 1'b1;
                    ack_q.delete(i);
                    break;
                end
            end
            iss_ready = 1'b1;
            if (iss_valid && n == hold_idx && hold_cnt < hold_len) begin
                iss_ready = 1'b0;
                hold_cnt++;
                chk("hold_a",  addr_a, exp_a[n]);
                chk("hold_b",  addr_b, exp_b[n]);
                chk("hold_tw", tw_idx, exp_tw[n]);
            end
            if (iss_valid && iss_ready) begin
                if (n < 12) begin
                    chk("iss_a",     addr_a, exp_a[n]);
                    chk("iss_b",     addr_b, exp_b[n]);
                    chk("iss_tw",    tw_idx, exp_tw[n]);
                    chk("iss_stage", stage,  n / 4);
                    if (n == 4) chk("barrier", cyc, s0_ack_cyc + 1);
                end else begin
                    chk("extra_issue", n, 11);
                end
                due = cyc + 1 + ((n == delay_idx) ? delay_len : 0);
                ack_q.push_back(due);
                if (n == 3) s0_ack_cyc = due;
                n++;
            end
            if (cyc == mid_start_cyc) start = 1'b1;
            if (done) begin
                dones++;
                done_cyc = cyc;
                fin = 1'b1;
                chk("fin_busy", busy, 0);
`ifdef FFT_SCHED_INV_EN
                chk("tw_conj_fin", tw_conj, inv_v);
`endif
                start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0; wb_ack = 1'b0;
        chk("post_done",  done,      0);
        chk("post_busy",  busy,      0);
        chk("post_valid", iss_valid, 0);
        chk("issues",     n,         12);
        chk("done_cyc",   done_cyc,  exp_done_cyc);
        chk("done_count", dones,     1);
        chk("err_clean",  err,       0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("rst");
        rst_n = 1'b1;

        // ready=1, immediate acks: 3*(4+1)+2 = 17 cycles, done in cycle 16
        run_xform(-1, 0, -1, 0, -1, 16, 1'b0);
        // stage1 pair (1,3) stalled 5 cycles
        run_xform(5, 5, -1, 0, -1, 21, 1'b0);
        // last stage0 ack delayed 10 cycles, stray start mid-transform
        run_xform(-1, 0, 3, 10, 8, 26, 1'b0);

        @(negedge clk);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        chk("err_set", err, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);

        start = 1'b1; iss_ready = 1'b1; oc = 0; s1_seen = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) chk("err_clr", err, 0);
            if (cyc == 3) chk("thr_valid3", iss_valid, 0);
            if (cyc == 4) chk("thr_valid4", iss_valid, 0);
            if (cyc == 5) begin
                chk("thr_valid5", iss_valid, 1);
                chk("thr_a", addr_a, 4);
                chk("thr_b", addr_b, 5);
            end
            wb_ack = (cyc == 4) || (cyc >= 5 && oc > 0);
            if (wb_ack) oc--;
            if (iss_valid && iss_ready) oc++;
            if (stage == 2'd1 && iss_valid) s1_seen++;
            if (s1_seen == 2) break;
        end
        chk("thr_reach_s1", s1_seen, 2);

        rst_n = 1'b0; wb_ack = 1'b0;
        #1;
        chk_idle_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
            chk("midrst_no_valid", iss_valid, 0);
        end

        run_xform(-1, 0, -1, 0, -1, 16, 1'b0);
`ifdef FFT_SCHED_INV_EN
        run_xform(-1, 0, -1, 0, -1, 16, 1'b1);
        run_xform(-1, 0, -1, 0, -1, 16, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bfly_sched.md
Name: fft_bfly_sched

Overview:
- In-place radix-2 DIT FFT butterfly scheduler; sits directly upstream of the butterfly unit.
- Walks every stage and pair of an N-point transform.
- For each butterfly, issues sample-memory read addresses (a, b) and the twiddle ROM index that feed the butterfly's a/b operands and cos_k/isin_k.
- Throttles on outstanding writebacks and enforces a stage barrier, so a stage never reads data the previous stage has not yet written.

Parameters:
- LOG2N, 3, log2 of FFT size N (N = 1<<LOG2N); legal range 2..12.
- MAX_OUT, 4, max butterflies issued but not yet acknowledged by writeback; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a transform; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when all stages have been issued and drained.
- iss_valid  out  1  butterfly issue valid.
- iss_ready  in  1  downstream accepts the issue.
- addr_a  out  LOG2N  read/write address of the upper operand.
- addr_b  out  LOG2N  read/write address of the lower operand.
- tw_idx  out  LOG2N-1  twiddle ROM index k for W_N^k.
- stage  out  $clog2(LOG2N)  current stage number.
- wb_ack  in  1  one pulse per butterfly result written back to memory.
- err  out  1  sticky; set when wb_ack arrives with zero outstanding; cleared only by reset or by an accepted start.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE;
  - busy, done, iss_valid, err = 0;
  - addr_a, addr_b, tw_idx, stage = 0;
  - pair counter j = 0, outstanding = 0.
  - Reset mid-transform abandons the transform; no done pulse.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 → RUN next cycle; s=0, j=0, err cleared, busy=1.
  - First iss_valid is asserted in the cycle after start (latency 1).
- Address mapping for stage s and pair j (0..N/2-1):
  - span = 1<<s; pos = j & (span-1); grp = j >> s;
  - addr_a = grp*2*span + pos; addr_b = addr_a + span;
  - tw_idx = pos << (LOG2N-1-s).
  - All outputs are registered.
- RUN:
  - iss_valid=1 whenever outstanding < MAX_OUT.
  - Transfer occurs on iss_valid && iss_ready.
  - addr_a/addr_b/tw_idx/stage are held stable while iss_valid && !iss_ready.
  - iss_valid is never dropped without a transfer.
  - On transfer with j < N/2-1: j++, and the next pair is presented the following cycle (one issue per cycle sustained).
  - On transfer with j = N/2-1: → DRAIN, iss_valid=0.
- Outstanding counter:
  - +1 on transfer, -1 on wb_ack.
  - Simultaneous transfer and wb_ack leaves it unchanged.
  - wb_ack with outstanding=0 sets err; the counter stays 0.
- DRAIN:
  - Waits until outstanding==0, counting an ack that arrives in the same cycle.
  - If s < LOG2N-1: s++, j=0 → RUN.
  - Otherwise → FIN.
- FIN: one cycle; done=1, busy=0; → IDLE.
  - start in the FIN cycle is ignored; start is accepted again from IDLE.
- Total issues per transform = LOG2N * N/2.
- Minimum transform duration with ready always 1 and immediate acks = LOG2N*(N/2 + 1) + 2 cycles.
- Widths: outstanding counter is $clog2(MAX_OUT+1) bits; no wrap is possible because issue is throttled at MAX_OUT.

Optional Feature:
- Macro: FFT_SCHED_INV_EN.
- With the macro defined:
  - Extra input inv (1 bit), sampled on the accepted start.
  - Extra output tw_conj (1 bit), driven with the latched inv for the whole transform; it tells the twiddle path to negate isin_k for an inverse FFT.
  - tw_conj resets to 0.
- Without the macro: neither port exists and the transform is forward only.

Decomposition:
- Shared package fft_pkg holds:
  - LOG2N/N defaults;
  - address, twiddle-index and stage width localparams (derived via $clog2);
  - state encoding typedef (IDLE, RUN, DRAIN, FIN).
  - The twiddle ROM and the butterfly datapath reuse the same widths.
- One sub-module, fft_pair_addr: combinational (s, j) → (addr_a, addr_b, tw_idx). Its outputs are registered in fft_bfly_sched.

Test Plan:
- LOG2N=3, iss_ready=1, wb_ack one cycle after each issue:
  - stage0 pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0;
  - stage1 pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2;
  - stage2 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3;
  - done pulses once, 12 issues total.
- MAX_OUT=2 with acks withheld: after 2 issues iss_valid=0. One wb_ack → iss_valid=1 next cycle with the third pair (4,5).
- iss_ready=0 for 5 cycles during stage1 pair (1,3): addr_a=1, addr_b=3, tw_idx=2 held constant, no skip, no duplicate.
- Stage barrier: last stage0 ack delayed 10 cycles → no stage1 issue until the cycle after that ack. A start pulse mid-transform is ignored.
- Error and reset:
  - wb_ack with 0 outstanding → err=1 and stays set.
  - rst_n=0 mid-stage1 → all outputs 0 immediately, no done.
  - Next start runs a full clean transform with err=0.
- FFT_SCHED_INV_EN defined: start with inv=1 → tw_conj=1 throughout the transform. Start with inv=0 → tw_conj=0.
